// File: rtl/vga_seq_pkg.sv
// rtl/vga_seq_pkg.sv - shared types and scene tables for the VGA scene sequencer
package vga_seq_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  localparam logic [1:0] FADE_FULL = 2'd3;

  // Checker layer enables per scene: bit0 = layer a ... bit4 = layer e.
  function automatic logic [4:0] layers_for(input logic [1:0] scene);
    logic [4:0] layers;
    unique case (scene)
      2'd0: layers = 5'b11111;
      2'd1: layers = 5'b00011;
      2'd2: layers = 5'b11100;
      2'd3: layers = 5'b10101;
    endcase
    return layers;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser with registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Bring the pin into the clk domain and emit one pulse per rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/vga_scene_sequencer.sv
// rtl/vga_scene_sequencer.sv - frame-rate scene, layer and fade sequencer for the checker demo
module vga_scene_sequencer #(
  parameter int CNT_W        = 10,
  parameter int SCENE_FRAMES = 600,
  parameter int FADE_STEP    = 4,
  parameter int NUM_SCENES   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_next,
  input  logic             btn_pause,
  input  logic             auto_en,
  input  logic [1:0]       speed,
  output logic [CNT_W-1:0] anim_counter,
  output logic [1:0]       scene_id,
  output logic [4:0]       layer_en,
  output logic [1:0]       fade_level,
  output logic             busy
);

  import vga_seq_pkg::*;

  localparam int DW = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
  localparam int TW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCENE_FRAMES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FADE_STEP - 1);
  localparam logic [1:0]    SCENE_LAST = 2'(NUM_SCENES - 1);

  seq_state_t       state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       fade_d;
  logic [1:0]       scene_d;
  logic [4:0]       layer_d;
  logic [CNT_W-1:0] anim_d;
  logic             paused_q;
  logic             next_pulse;
  logic             pause_pulse;
  logic             step_en;

  btn_sync_edge u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .pulse (next_pulse)
  );

  btn_sync_edge u_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .pulse (pause_pulse)
  );

  // Pause only freezes the animation counter and the scene dwell timer.
  assign step_en = frame_tick & ~paused_q;

  // Next-state and next-output decode; fades advance on every tick regardless of pause.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    timer_d = timer_q;
    fade_d  = fade_level;
    scene_d = scene_id;
    layer_d = layer_en;
    anim_d  = step_en ? anim_counter + CNT_W'(speed) + CNT_W'(1) : anim_counter;
    unique case (state_q)
      SHOW: begin
        if (next_pulse) begin
          state_d = FADE_OUT;
          dwell_d = '0;
          timer_d = '0;
        end else if (step_en && auto_en) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = FADE_OUT;
            dwell_d = '0;
            timer_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      FADE_OUT: begin
        if (frame_tick) begin
          if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            fade_d  = fade_level - 2'd1;
            if (fade_level == 2'd1) state_d = SWITCH;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      SWITCH: begin
        scene_d = (scene_id == SCENE_LAST) ? 2'd0 : scene_id + 2'd1;
        layer_d = layers_for(scene_d);
        anim_d  = '0;
        dwell_d = '0;
        timer_d = '0;
        state_d = FADE_IN;
      end
      FADE_IN: begin
        if (frame_tick) begin
          if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            fade_d  = fade_level + 2'd1;
            if (fade_level == 2'd2) state_d = SHOW;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State and registered outputs; busy reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SHOW;
      dwell_q      <= '0;
      timer_q      <= '0;
      paused_q     <= 1'b0;
      anim_counter <= '0;
      scene_id     <= 2'd0;
      layer_en     <= layers_for(2'd0);
      fade_level   <= FADE_FULL;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      timer_q      <= timer_d;
      paused_q     <= paused_q ^ pause_pulse;
      anim_counter <= anim_d;
      scene_id     <= scene_d;
      layer_en     <= layer_d;
      fade_level   <= fade_d;
      busy         <= (state_d != SHOW);
    end
  end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// tb/tb_vga_scene_sequencer.sv - self-checking bench for vga_scene_sequencer
module tb_vga_scene_sequencer;

  localparam int SF = 5;
  localparam int FS = 2;
  localparam int NS = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          btn_next = 1'b0;
  logic          btn_pause = 1'b0;
  logic          auto_en = 1'b1;
  logic [1:0]    speed = 2'd0;
  logic [CW-1:0] anim_counter;
  logic [1:0]    scene_id;
  logic [4:0]    layer_en;
  logic [1:0]    fade_level;
  logic          busy;

  vga_scene_sequencer #(
    .CNT_W(CW), .SCENE_FRAMES(SF), .FADE_STEP(FS), .NUM_SCENES(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_next(btn_next),
    .btn_pause(btn_pause), .auto_en(auto_en), .speed(speed),
    .anim_counter(anim_counter), .scene_id(scene_id), .layer_en(layer_en),
    .fade_level(fade_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [4:0] exp_layers [4] = '{5'b11111, 5'b00011, 5'b11100, 5'b10101};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 show, 1 fade out, 2 switch, 3 fade in.
  // Fade level is derived from the number of ticks spent in the fade.
  int         m_phase, m_ticks, m_anim, m_scene, m_dwell;
  bit         m_paused;
  bit         m_ok = 1'b0;
  logic [4:1] m_nh, m_ph;

  function automatic int m_fade();
    case (m_phase)
      0:       return 3;
      1:       return 3 - m_ticks / FS;
      2:       return 0;
      default: return m_ticks / FS;
    endcase
  endfunction

  always @(posedge clk) begin
    bit nx, pz, adv;
    if (!rst_n) begin
      m_phase = 0; m_ticks = 0; m_anim = 0; m_scene = 0; m_dwell = 0;
      m_paused = 1'b0; m_nh = '0; m_ph = '0; m_ok = 1'b1;
    end else begin
      nx = m_nh[3] & ~m_nh[4];
      pz = m_ph[3] & ~m_ph[4];
      m_nh = {m_nh[3:1], btn_next};
      m_ph = {m_ph[3:1], btn_pause};
      adv = frame_tick && !m_paused;
      if (m_phase != 2 && adv) m_anim = (m_anim + int'(speed) + 1) % (1 << CW);
      case (m_phase)
        0: begin
          if (nx) begin
            m_phase = 1; m_ticks = 0; m_dwell = 0;
          end else if (adv && auto_en) begin
            m_dwell++;
            if (m_dwell == SF) begin
              m_phase = 1; m_ticks = 0; m_dwell = 0;
            end
          end
        end
        1: if (frame_tick) begin
          m_ticks++;
          if (m_ticks == 3 * FS) m_phase = 2;
        end
        2: begin
          m_scene = (m_scene + 1) % NS;
          m_anim = 0; m_dwell = 0; m_ticks = 0; m_phase = 3;
        end
        default: if (frame_tick) begin
          m_ticks++;
          if (m_ticks == 3 * FS) m_phase = 0;
        end
      endcase
      if (pz) m_paused = !m_paused;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("anim", int'(anim_counter), m_anim);
      chk("scene", int'(scene_id), m_scene);
      chk("layer", int'(layer_en), int'(exp_layers[m_scene]));
      chk("fade", int'(fade_level), m_fade());
      chk("busy", int'(busy), int'(m_phase != 0));
    end
  end

  task automatic step(input logic ft);
    frame_tick = ft;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_anim"}, int'(anim_counter), 0);
    chk({tag, "_scene"}, int'(scene_id), 0);
    chk({tag, "_layer"}, int'(layer_en), 5'b11111);
    chk({tag, "_fade"}, int'(fade_level), 3);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  int fo [6] = '{3, 2, 2, 1, 1, 0};
  int fi [6] = '{0, 1, 1, 2, 2, 3};
  int seq [4] = '{1, 2, 3, 0};
  int lay [4] = '{5'b00011, 5'b11100, 5'b10101, 5'b11111};

  initial begin
    // Reset state
    rst_n = 1'b0;
    step(1'b0);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Counter step and wrap
    auto_en = 1'b0;
    speed = 2'd3;
    tick(10);
    chk("anim_speed3", int'(anim_counter), 40);
    tick(245);
    speed = 2'd2;
    tick(1);
    chk("anim_1023", int'(anim_counter), 1023);
    speed = 2'd0;
    tick(2);
    chk("anim_wrap", int'(anim_counter), 1);

    // Auto-advance through a full transition
    auto_en = 1'b1;
    do_reset();
    tick(4);
    chk("dwell_busy", int'(busy), 0);
    step(1'b1);
    chk("enter_fo_busy", int'(busy), 1);
    chk("enter_fo_fade", int'(fade_level), 3);
    step(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("fo_fade", int'(fade_level), fo[i]);
      step(1'b0);
    end
    chk("sw_scene", int'(scene_id), 1);
    chk("sw_layer", int'(layer_en), 5'b00011);
    chk("sw_anim", int'(anim_counter), 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("fi_fade", int'(fade_level), fi[i]);
      step(1'b0);
    end
    chk("fi_busy", int'(busy), 0);

    // Reset in the middle of a fade-out
    tick(5);
    tick(2);
    chk("mid_fade", int'(fade_level), 2);
    rst_n = 1'b0;
    step(1'b0);
    check_reset_values("rst_mid");
    rst_n = 1'b1;

    // Pause freezes counter and dwell, fades still run
    tick(2);
    btn_pause = 1'b1;
    step(1'b0); step(1'b0);
    btn_pause = 1'b0;
    repeat (4) step(1'b0);
    tick(20);
    chk("pause_anim", int'(anim_counter), 2);
    chk("pause_busy", int'(busy), 0);
    chk("pause_scene", int'(scene_id), 0);
    btn_next = 1'b1;
    step(1'b0); step(1'b0);
    btn_next = 1'b0;
    repeat (4) step(1'b0);
    chk("pause_next_busy", int'(busy), 1);
    tick(12);
    chk("pause_done_busy", int'(busy), 0);
    chk("pause_done_scene", int'(scene_id), 1);
    chk("pause_done_anim", int'(anim_counter), 0);

    // Next pulse coinciding with a tick, repeats dropped during the fade
    do_reset();
    tick(1);
    btn_next = 1'b1;
    step(1'b0); step(1'b0); step(1'b0);
    step(1'b1);
    btn_next = 1'b0;
    chk("coinc_anim", int'(anim_counter), 2);
    chk("coinc_busy", int'(busy), 1);
    repeat (3) begin
      btn_next = 1'b1;
      step(1'b1);
      step(1'b0);
      btn_next = 1'b0;
      step(1'b0);
      step(1'b0);
    end
    tick(3);
    tick(6);
    chk("drop_busy", int'(busy), 0);
    chk("drop_scene", int'(scene_id), 1);
    tick(3);
    chk("drop_scene_after", int'(scene_id), 1);

    // Four consecutive scene advances
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(5);
      tick(6);
      chk("seq_scene", int'(scene_id), seq[k]);
      chk("seq_layer", int'(layer_en), lay[k]);
      tick(6);
    end

    // Randomized stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      speed = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    rst_n = 1'b1;
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
